round_timer_fsm: RTL and testbench

- Game-round countdown timer for ByteBasher; sits directly upstream of the two hex_decoder instances driving HEX1/HEX0.
- Divides the system clock to a 1 s tick internally and counts down from ROUND_SECONDS in BCD (tens/ones).
- Runs a round state machine (idle/run/pause/done) and flags round end to the game logic.

---
 rtl/round_timer_fsm_if.sv | 23 ++
 rtl/round_timer_fsm.sv | 113 +++++++++++
 tb/tb_round_timer_fsm.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/round_timer_fsm_if.sv
// Control and display bundle between the game logic and the round timer.
// The game logic is the master and the timer is the slave.
interface round_timer_fsm_if;
   logic       Start;
   logic       Pause;
   logic       Abort;
   logic [3:0] TensDigit;
   logic [3:0] OnesDigit;
   logic       Running;
   logic       Expired;
   logic       TimeUp;
   logic       WarnLow;

   modport master (
      output Start, Pause, Abort,
      input  TensDigit, OnesDigit, Running, Expired, TimeUp, WarnLow
   );

   modport slave (
      input  Start, Pause, Abort,
      output TensDigit, OnesDigit, Running, Expired, TimeUp, WarnLow
   );
endinterface

// File: rtl/round_timer_fsm.sv
// ByteBasher round countdown timer: a 1 s prescaler feeds a BCD down-counter,
// and an idle/run/pause/done FSM drives the round flags and the HEX digits.
module round_timer_fsm #(
   parameter int unsigned CLOCK_FREQUENCY = 50000000,
   parameter int unsigned ROUND_SECONDS   = 60
) (
   input logic              ClockIn,
   input logic              ResetN,
   round_timer_fsm_if.slave Bus
);

   localparam int unsigned PreW     = (CLOCK_FREQUENCY > 2) ? $clog2(CLOCK_FREQUENCY) : 1;
   localparam logic [PreW-1:0] PreLoad  = PreW'(CLOCK_FREQUENCY - 1);
   localparam logic [3:0]      LoadTens = 4'(ROUND_SECONDS / 10);
   localparam logic [3:0]      LoadOnes = 4'(ROUND_SECONDS % 10);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StDone  = 2'd3
   } stateT;

   stateT           state, stateNext;
   logic [PreW-1:0] presc, prescNext;
   logic [3:0]      tens, tensNext;
   logic [3:0]      ones, onesNext;
   logic            running, runningNext;
   logic            expired, expiredNext;
   logic            timeUp, timeUpNext;

   // State, counter and flag registers
   always_ff @(posedge ClockIn or negedge ResetN) begin
      if (!ResetN) begin
         state   <= StIdle;
         presc   <= PreLoad;
         tens    <= LoadTens;
         ones    <= LoadOnes;
         running <= 1'b0;
         expired <= 1'b0;
         timeUp  <= 1'b0;
      end else begin
         state   <= stateNext;
         presc   <= prescNext;
         tens    <= tensNext;
         ones    <= onesNext;
         running <= runningNext;
         expired <= expiredNext;
         timeUp  <= timeUpNext;
      end
   end

   // Next state: Abort beats Start beats Pause beats the 1 s tick
   always_comb begin
      stateNext  = state;
      prescNext  = presc;
      tensNext   = tens;
      onesNext   = ones;
      timeUpNext = 1'b0;

      if (Bus.Abort) begin
         stateNext = StIdle;
         prescNext = PreLoad;
         tensNext  = LoadTens;
         onesNext  = LoadOnes;
      end else if (Bus.Start) begin
         stateNext = Bus.Pause ? StPause : StRun;
         prescNext = PreLoad;
         tensNext  = LoadTens;
         onesNext  = LoadOnes;
      end else begin
         unique case (state)
            StRun: begin
               if (Bus.Pause) begin
                  stateNext = StPause;
               end else if (presc == '0) begin
                  prescNext = PreLoad;
                  if (tens == 4'd0 && ones == 4'd1) begin
                     onesNext   = 4'd0;
                     stateNext  = StDone;
                     timeUpNext = 1'b1;
                  end else if (ones == 4'd0) begin
                     onesNext = 4'd9;
                     tensNext = tens - 4'd1;
                  end else begin
                     onesNext = ones - 4'd1;
                  end
               end else begin
                  prescNext = presc - PreW'(1);
               end
            end
            StPause: begin
               if (!Bus.Pause) stateNext = StRun;
            end
            default: begin
            end
         endcase
      end

      runningNext = (stateNext == StRun);
      expiredNext = (stateNext == StDone);
   end

   assign Bus.TensDigit = tens;
   assign Bus.OnesDigit = ones;
   assign Bus.Running   = running;
   assign Bus.Expired   = expired;
   assign Bus.TimeUp    = timeUp;
   // Low-time warning decodes straight from the registered state and digits
   assign Bus.WarnLow   = (state == StRun || state == StPause) &&
                          (tens == 4'd0 || (tens == 4'd1 && ones == 4'd0));

endmodule

// File: tb/tb_round_timer_fsm.sv
// Bench for round_timer_fsm: directed round scenarios plus random control
// traffic, checked against a seconds-remaining model of the round.
module tb_round_timer_fsm;

   localparam int CF = 4;
   localparam int RS = 12;

   localparam int PhIdle = 0;
   localparam int PhRun  = 1;
   localparam int PhHold = 2;
   localparam int PhOver = 3;

   logic ClockIn = 1'b0;
   logic ResetN  = 1'b0;

   round_timer_fsm_if busA ();
   round_timer_fsm_if busB ();

   round_timer_fsm #(.CLOCK_FREQUENCY(CF), .ROUND_SECONDS(RS)) dutMain (
      .ClockIn(ClockIn),
      .ResetN (ResetN),
      .Bus    (busA)
   );

   round_timer_fsm #(.CLOCK_FREQUENCY(2), .ROUND_SECONDS(1)) dutEdge (
      .ClockIn(ClockIn),
      .ResetN (ResetN),
      .Bus    (busB)
   );

   always #5 ClockIn = ~ClockIn;

   int checks = 0;
   int errors = 0;

   // Round model: whole seconds left, cycles left until the next second
   int mRem;
   int mLeft;
   int mPhase;
   bit mPulse;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mRem   = RS;
      mLeft  = CF - 1;
      mPhase = PhIdle;
      mPulse = 1'b0;
   endtask

   task automatic modelStep(input bit s, input bit p, input bit a);
      mPulse = 1'b0;
      if (a) begin
         modelReset();
      end else if (s) begin
         mRem   = RS;
         mLeft  = CF - 1;
         mPhase = p ? PhHold : PhRun;
      end else if (mPhase == PhRun) begin
         if (p) begin
            mPhase = PhHold;
         end else if (mLeft == 0) begin
            mLeft = CF - 1;
            mRem  = mRem - 1;
            if (mRem == 0) begin
               mPhase = PhOver;
               mPulse = 1'b1;
            end
         end else begin
            mLeft = mLeft - 1;
         end
      end else if (mPhase == PhHold && !p) begin
         mPhase = PhRun;
      end
   endtask

   task automatic checkAll(input string tag);
      chk({tag, "_tens"},    32'(busA.TensDigit), 32'(mRem / 10));
      chk({tag, "_ones"},    32'(busA.OnesDigit), 32'(mRem % 10));
      chk({tag, "_running"}, 32'(busA.Running),   32'(mPhase == PhRun));
      chk({tag, "_expired"}, 32'(busA.Expired),   32'(mPhase == PhOver));
      chk({tag, "_timeup"},  32'(busA.TimeUp),    32'(mPulse));
      chk({tag, "_warnlow"}, 32'(busA.WarnLow),
          32'((mPhase == PhRun || mPhase == PhHold) && mRem <= 10));
   endtask

   // One clock: drive at the falling edge, model on the rising edge, check at the next falling edge
   task automatic step(input bit s, input bit p, input bit a, input string tag);
      busA.Start = s;
      busA.Pause = p;
      busA.Abort = a;
      @(posedge ClockIn);
      modelStep(s, p, a);
      @(negedge ClockIn);
      checkAll(tag);
   endtask

   task automatic edgeStep(input bit s, input bit p);
      busB.Start = s;
      busB.Pause = p;
      step(1'b0, 1'b0, 1'b0, "edge_main");
   endtask

   task automatic runUntilRem(input int target, input bit needZeroLeft, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (mRem == target && (!needZeroLeft || mLeft == 0)) begin
            hit = 1'b1;
            break;
         end
         step(1'b0, 1'b0, 1'b0, tag);
      end
      chk({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   initial begin
      int pulses;
      bit rp;

      busA.Start = 1'b0; busA.Pause = 1'b0; busA.Abort = 1'b0;
      busB.Start = 1'b0; busB.Pause = 1'b0; busB.Abort = 1'b0;
      modelReset();

      // Reset values, held and after release
      repeat (2) @(negedge ClockIn);
      checkAll("reset_held");
      ResetN = 1'b1;
      @(negedge ClockIn);
      checkAll("reset_release");
      chk("reset_tens_const", 32'(busA.TensDigit), 32'd1);
      chk("reset_ones_const", 32'(busA.OnesDigit), 32'd2);

      // Full countdown to DONE and 20 idle cycles beyond
      step(1'b1, 1'b0, 1'b0, "count_start");
      chk("count_start_running", 32'(busA.Running), 32'd1);
      pulses = 0;
      for (int i = 0; i < 60 && !busA.Expired; i++) begin
         step(1'b0, 1'b0, 1'b0, "count");
         if (busA.TimeUp === 1'b1) pulses++;
      end
      chk("count_expired", 32'(busA.Expired), 32'd1);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0, "count_hold");
         if (busA.TimeUp === 1'b1) pulses++;
      end
      chk("count_timeup_pulses", 32'(pulses), 32'd1);
      chk("count_final_ones", 32'(busA.OnesDigit), 32'd0);

      // Pause asserted in the cycle where the prescaler is 0 at 07
      step(1'b1, 1'b0, 1'b0, "pause_start");
      runUntilRem(7, 1'b1, "pause_seek");
      step(1'b0, 1'b1, 1'b0, "pause_edge");
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0, "pause_hold");
         chk("pause_hold_ones", 32'(busA.OnesDigit), 32'd7);
         chk("pause_hold_running", 32'(busA.Running), 32'd0);
      end
      step(1'b0, 1'b0, 1'b0, "pause_resume");
      step(1'b0, 1'b0, 1'b0, "pause_tick");
      chk("pause_tick_ones", 32'(busA.OnesDigit), 32'd6);
      repeat (4) step(1'b0, 1'b0, 1'b0, "pause_next");
      chk("pause_next_ones", 32'(busA.OnesDigit), 32'd5);

      // Restart at 05, then Abort together with Start at 08
      runUntilRem(5, 1'b0, "restart_seek");
      step(1'b1, 1'b0, 1'b0, "restart");
      chk("restart_tens", 32'(busA.TensDigit), 32'd1);
      chk("restart_timeup", 32'(busA.TimeUp), 32'd0);
      runUntilRem(8, 1'b0, "abort_seek");
      step(1'b1, 1'b0, 1'b1, "abort_start");
      chk("abort_running", 32'(busA.Running), 32'd0);
      chk("abort_ones", 32'(busA.OnesDigit), 32'd2);

      // Start from DONE reloads and runs
      step(1'b1, 1'b0, 1'b0, "done_seek_start");
      runUntilRem(0, 1'b0, "done_seek");
      repeat (3) step(1'b0, 1'b0, 1'b0, "done_wait");
      step(1'b1, 1'b0, 1'b0, "done_restart");
      chk("done_restart_running", 32'(busA.Running), 32'd1);

      // Random control traffic
      rp = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) rp = ~rp;
         step(($urandom_range(0, 24) == 0), rp,
              ($urandom_range(0, 59) == 0), "random");
      end

      // Asynchronous reset mid-RUN, observed before any clock edge
      step(1'b1, 1'b0, 1'b0, "areset_start");
      repeat (6) step(1'b0, 1'b0, 1'b0, "areset_run");
      #2;
      ResetN = 1'b0;
      #1;
      modelReset();
      checkAll("areset_now");
      @(negedge ClockIn);
      ResetN = 1'b1;
      @(negedge ClockIn);
      checkAll("areset_release");

      // ROUND_SECONDS=1, CLOCK_FREQUENCY=2 instance
      chk("edge_reset_ones", 32'(busB.OnesDigit), 32'd1);
      chk("edge_reset_tens", 32'(busB.TensDigit), 32'd0);
      edgeStep(1'b1, 1'b0);
      chk("edge_start_running", 32'(busB.Running), 32'd1);
      chk("edge_start_ones", 32'(busB.OnesDigit), 32'd1);
      edgeStep(1'b0, 1'b0);
      chk("edge_mid_ones", 32'(busB.OnesDigit), 32'd1);
      chk("edge_mid_timeup", 32'(busB.TimeUp), 32'd0);
      edgeStep(1'b0, 1'b0);
      chk("edge_done_ones", 32'(busB.OnesDigit), 32'd0);
      chk("edge_done_timeup", 32'(busB.TimeUp), 32'd1);
      chk("edge_done_expired", 32'(busB.Expired), 32'd1);
      chk("edge_done_running", 32'(busB.Running), 32'd0);
      edgeStep(1'b0, 1'b0);
      chk("edge_after_timeup", 32'(busB.TimeUp), 32'd0);
      chk("edge_after_expired", 32'(busB.Expired), 32'd1);
      edgeStep(1'b1, 1'b1);
      chk("edge_pause_running", 32'(busB.Running), 32'd0);
      chk("edge_pause_expired", 32'(busB.Expired), 32'd0);
      chk("edge_pause_ones", 32'(busB.OnesDigit), 32'd1);
      chk("edge_pause_warn", 32'(busB.WarnLow), 32'd1);
      edgeStep(1'b1, 1'b1);
      chk("edge_pause2_running", 32'(busB.Running), 32'd0);
      edgeStep(1'b0, 1'b0);
      chk("edge_resume_running", 32'(busB.Running), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
